// File: rtl/hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hit_arbiter
// Purpose  : Resolves attack requests from both players during a round and
//            owns both health registers. Each attack is checked against
//            reach, the opponent's block and the opponent's post-hit
//            invulnerability window. It also enforces per-player attack
//            cooldown and invulnerability (i-frame) timers. The block is
//            active only while the game FSM reports the fight state.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   60 Hz game clock
//   reset           in   synchronous, active-high reset
//   game_state      in   game FSM state (fight = 3'd2)
//   p1_attack       in   player 1 attack request (level, sampled every cycle)
//   p2_attack       in   player 2 attack request (level, sampled every cycle)
//   p1_block        in   player 1 is blocking
//   p2_block        in   player 2 is blocking
//   in_range        in   players are within striking reach
//   player1_health  out  registered player 1 health
//   player2_health  out  registered player 2 health
//   p1_landed       out  one-cycle pulse: player 1 damaged player 2
//   p2_landed       out  one-cycle pulse: player 2 damaged player 1
//   p1_busy         out  player 1 attack cooldown is nonzero
//   p2_busy         out  player 2 attack cooldown is nonzero
//   ko              out  registered, high while in the KO state
// ============================================================================
module hit_arbiter #(
  parameter logic [2:0] MAX_HEALTH = 3'd5,
  parameter logic [2:0] DAMAGE     = 3'd1,
  parameter int         COOLDOWN   = 30,
  parameter int         IFRAMES    = 20,
  parameter int         CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       p1_attack,
  input  logic       p2_attack,
  input  logic       p1_block,
  input  logic       p2_block,
  input  logic       in_range,
  output logic [2:0] player1_health,
  output logic [2:0] player2_health,
  output logic       p1_landed,
  output logic       p2_landed,
  output logic       p1_busy,
  output logic       p2_busy,
  output logic       ko
);

  localparam logic [2:0]       FIGHT_STATE  = 3'd2;
  localparam logic [CNT_W-1:0] CD_LOAD      = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] IF_LOAD      = CNT_W'(IFRAMES);
  localparam logic [CNT_W-1:0] TIMER_ZERO   = '0;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_LOAD     = 2'd1,
    S_ACTIVE   = 2'd2,
    S_KO       = 2'd3
  } state_t;

  state_t state, state_next;

  // Timers: cooldown belongs to the attacker, i-frame to the defender.
  logic [CNT_W-1:0] p1_cd, p2_cd, p1_if, p2_if;
  logic [CNT_W-1:0] p1_cd_next, p2_cd_next, p1_if_next, p2_if_next;
  logic [2:0]       p1_health_next, p2_health_next;
  logic             p1_landed_next, p2_landed_next;
  logic             fight;
  logic             p1_accept, p2_accept;
  logic             p1_hits, p2_hits;

  // Count down by one, holding at zero.
  function automatic logic [CNT_W-1:0] tick_down(input logic [CNT_W-1:0] t);
    return (t != TIMER_ZERO) ? (t - 1'b1) : TIMER_ZERO;
  endfunction

  // Damage never wraps the 3-bit health below zero.
  function automatic logic [2:0] take_damage(input logic [2:0] h);
    return (h >= DAMAGE) ? (h - DAMAGE) : 3'd0;
  endfunction

  assign fight   = (game_state == FIGHT_STATE);
  assign p1_busy = (p1_cd != TIMER_ZERO);
  assign p2_busy = (p2_cd != TIMER_ZERO);

  // Resolution terms use the pre-update register values so both players are
  // judged against the same snapshot, which makes simultaneous trades fair.
  assign p1_accept = p1_attack && (p1_cd == TIMER_ZERO);
  assign p2_accept = p2_attack && (p2_cd == TIMER_ZERO);
  assign p1_hits   = p1_accept && in_range && !p2_block && (p2_if == TIMER_ZERO);
  assign p2_hits   = p2_accept && in_range && !p1_block && (p1_if == TIMER_ZERO);

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_DISABLED;
      player1_health <= MAX_HEALTH;
      player2_health <= MAX_HEALTH;
      p1_cd          <= TIMER_ZERO;
      p2_cd          <= TIMER_ZERO;
      p1_if          <= TIMER_ZERO;
      p2_if          <= TIMER_ZERO;
      p1_landed      <= 1'b0;
      p2_landed      <= 1'b0;
      ko             <= 1'b0;
    end else begin
      state          <= state_next;
      player1_health <= p1_health_next;
      player2_health <= p2_health_next;
      p1_cd          <= p1_cd_next;
      p2_cd          <= p2_cd_next;
      p1_if          <= p1_if_next;
      p2_if          <= p2_if_next;
      p1_landed      <= p1_landed_next;
      p2_landed      <= p2_landed_next;
      ko             <= (state_next == S_KO);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    p1_health_next = player1_health;
    p2_health_next = player2_health;
    p1_cd_next     = tick_down(p1_cd);
    p2_cd_next     = tick_down(p2_cd);
    p1_if_next     = tick_down(p1_if);
    p2_if_next     = tick_down(p2_if);
    p1_landed_next = 1'b0;
    p2_landed_next = 1'b0;

    case (state)
      S_DISABLED: begin
        p1_cd_next = TIMER_ZERO;
        p2_cd_next = TIMER_ZERO;
        p1_if_next = TIMER_ZERO;
        p2_if_next = TIMER_ZERO;
        if (fight) begin
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        p1_health_next = MAX_HEALTH;
        p2_health_next = MAX_HEALTH;
        p1_cd_next     = TIMER_ZERO;
        p2_cd_next     = TIMER_ZERO;
        p1_if_next     = TIMER_ZERO;
        p2_if_next     = TIMER_ZERO;
        state_next     = fight ? S_ACTIVE : S_DISABLED;
      end

      S_ACTIVE: begin
        if (!fight) begin
          // Leaving the fight wins over any request this cycle.
          state_next = S_DISABLED;
        end else begin
          // A whiffed or blocked attack still costs the attacker its cooldown.
          if (p1_accept) p1_cd_next = CD_LOAD;
          if (p2_accept) p2_cd_next = CD_LOAD;

          if (p1_hits) begin
            p2_health_next = take_damage(player2_health);
            p2_if_next     = IF_LOAD;
            p1_landed_next = 1'b1;
          end
          if (p2_hits) begin
            p1_health_next = take_damage(player1_health);
            p1_if_next     = IF_LOAD;
            p2_landed_next = 1'b1;
          end

          if ((p1_health_next == 3'd0) || (p2_health_next == 3'd0)) begin
            state_next = S_KO;
          end
        end
      end

      S_KO: begin
        // Requests ignored, timers keep draining.
        if (!fight) begin
          state_next = S_DISABLED;
        end
      end

      default: begin
        state_next = S_DISABLED;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_arbiter
// Purpose  : Directed self-checking bench for hit_arbiter. Inputs are driven
//            1 time unit after each rising edge and outputs are sampled at
//            the same point, so every check sees the state produced by the
//            most recent edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_hit_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] game_state;
  logic       p1_attack, p2_attack, p1_block, p2_block, in_range;
  logic [2:0] player1_health, player2_health;
  logic       p1_landed, p2_landed, p1_busy, p2_busy, ko;

  int tests_run = 0;
  int tests_failed = 0;

  hit_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .game_state     (game_state),
    .p1_attack      (p1_attack),
    .p2_attack      (p2_attack),
    .p1_block       (p1_block),
    .p2_block       (p2_block),
    .in_range       (in_range),
    .player1_health (player1_health),
    .player2_health (player2_health),
    .p1_landed      (p1_landed),
    .p2_landed      (p2_landed),
    .p1_busy        (p1_busy),
    .p2_busy        (p2_busy),
    .ko             (ko)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    p1_attack = 1'b0;
    p2_attack = 1'b0;
    p1_block  = 1'b0;
    p2_block  = 1'b0;
    in_range  = 1'b0;
  endtask

  // Reset, then enter the fight: DISABLED -> LOAD -> ACTIVE.
  task automatic new_round();
    clear_inputs();
    game_state = 3'd0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    game_state = 3'd2;
    step(2);
  endtask

  task automatic test_reset();
    clear_inputs();
    game_state = 3'd0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    tests_run++;
    if ({player1_health, player2_health, p1_busy, p2_busy, p1_landed, p2_landed, ko}
        !== {3'd5, 3'd5, 5'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got h1=%0d h2=%0d b=%b%b l=%b%b ko=%b, want 5 5 00 00 0",
               player1_health, player2_health, p1_busy, p2_busy, p1_landed, p2_landed, ko);
    end
  endtask

  // Attack held from cycle M: ignored in DISABLED/LOAD, accepted at M+2.
  task automatic test_round_start_single_hit();
    clear_inputs();
    game_state = 3'd2;
    p1_attack = 1'b1;
    in_range = 1'b1;
    step(2);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, p1_busy, p1_landed} !== {3'd5, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL early_accept: got h2=%0d busy=%b landed=%b, want 5 0 0",
               player2_health, p1_busy, p1_landed);
    end
    p1_attack = 1'b1;
    step(1);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, player1_health, p1_landed, p1_busy} !== {3'd4, 3'd5, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_hit: got h2=%0d h1=%0d landed=%b busy=%b, want 4 5 1 1",
               player2_health, player1_health, p1_landed, p1_busy);
    end
    step(1);
    tests_run++;
    if (p1_landed !== 1'b0) begin
      tests_failed++;
      $display("FAIL landed_pulse_width: got %b, want 0", p1_landed);
    end
    step(28);
    tests_run++;
    if (p1_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_cycle30: got %b, want 1", p1_busy);
    end
    step(1);
    tests_run++;
    if (p1_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_cycle31: got %b, want 0", p1_busy);
    end
  endtask

  // Held request: hits at offsets 0, 31, 62, 93; health 5 -> 1.
  task automatic test_held_attack();
    int landed_bad;
    new_round();
    in_range = 1'b1;
    p1_attack = 1'b1;
    landed_bad = 0;
    for (int k = 0; k < 100; k++) begin
      logic exp_l;
      step(1);
      exp_l = (k == 0) || (k == 31) || (k == 62) || (k == 93);
      if (p1_landed !== exp_l) landed_bad++;
    end
    p1_attack = 1'b0;
    tests_run++;
    if (landed_bad != 0) begin
      tests_failed++;
      $display("FAIL held_attack_pulses: got %0d wrong cycles, want 0", landed_bad);
    end
    tests_run++;
    if ({player2_health, ko} !== {3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL held_attack_health: got h2=%0d ko=%b, want 1 0", player2_health, ko);
    end
  endtask

  task automatic test_block_and_range();
    new_round();
    in_range = 1'b1;
    p2_block = 1'b1;
    p1_attack = 1'b1;
    step(1);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, p1_landed, p1_busy} !== {3'd5, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL blocked: got h2=%0d landed=%b busy=%b, want 5 0 1",
               player2_health, p1_landed, p1_busy);
    end
    step(29);
    tests_run++;
    if (p1_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL blocked_busy30: got %b, want 1", p1_busy);
    end
    step(1);
    p2_block = 1'b0;
    in_range = 1'b0;
    p1_attack = 1'b1;
    step(1);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, p1_landed, p1_busy} !== {3'd5, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL out_of_range: got h2=%0d landed=%b busy=%b, want 5 0 1",
               player2_health, p1_landed, p1_busy);
    end
  endtask

  // Leaving the fight state takes priority over a request in the same cycle.
  task automatic test_exit_priority();
    new_round();
    in_range = 1'b1;
    p1_attack = 1'b1;
    game_state = 3'd0;
    step(3);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, p1_busy, p1_landed} !== {3'd5, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL exit_priority: got h2=%0d busy=%b landed=%b, want 5 0 0",
               player2_health, p1_busy, p1_landed);
    end
  endtask

  // Both players trade every 31 cycles: 5 trades reach a double KO at 124.
  task automatic test_double_ko();
    new_round();
    in_range = 1'b1;
    p1_attack = 1'b1;
    p2_attack = 1'b1;
    step(124);
    tests_run++;
    if ({player1_health, player2_health, ko} !== {3'd1, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL trade_pre_ko: got h1=%0d h2=%0d ko=%b, want 1 1 0",
               player1_health, player2_health, ko);
    end
    step(1);
    tests_run++;
    if ({player1_health, player2_health, p1_landed, p2_landed, ko}
        !== {3'd0, 3'd0, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL double_ko: got h1=%0d h2=%0d l=%b%b ko=%b, want 0 0 11 1",
               player1_health, player2_health, p1_landed, p2_landed, ko);
    end
    step(40);
    tests_run++;
    if ({player1_health, player2_health, p1_landed, p2_landed, p1_busy, p2_busy, ko}
        !== {3'd0, 3'd0, 4'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ko_ignores: got h1=%0d h2=%0d l=%b%b b=%b%b ko=%b, want 0 0 00 00 1",
               player1_health, player2_health, p1_landed, p2_landed, p1_busy, p2_busy, ko);
    end
    p1_attack = 1'b0;
    p2_attack = 1'b0;
    game_state = 3'd5;
    step(3);
    tests_run++;
    if ({player1_health, player2_health, ko} !== {3'd0, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL disabled_hold: got h1=%0d h2=%0d ko=%b, want 0 0 0",
               player1_health, player2_health, ko);
    end
    game_state = 3'd2;
    step(1);
    tests_run++;
    if ({player1_health, player2_health} !== {3'd0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reentry_pre_load: got h1=%0d h2=%0d, want 0 0",
               player1_health, player2_health);
    end
    step(1);
    tests_run++;
    if ({player1_health, player2_health} !== {3'd5, 3'd5}) begin
      tests_failed++;
      $display("FAIL reentry_load: got h1=%0d h2=%0d, want 5 5",
               player1_health, player2_health);
    end
  endtask

  task automatic test_reset_mid_round();
    new_round();
    in_range = 1'b1;
    p1_attack = 1'b1;
    step(63);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, p1_busy} !== {3'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_setup: got h2=%0d busy=%b, want 2 1", player2_health, p1_busy);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    tests_run++;
    if ({player1_health, player2_health, p1_busy, p2_busy, ko} !== {3'd5, 3'd5, 3'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got h1=%0d h2=%0d b=%b%b ko=%b, want 5 5 00 0",
               player1_health, player2_health, p1_busy, p2_busy, ko);
    end
    // Now DISABLED: requests must be ignored while out of the fight.
    game_state = 3'd0;
    p1_attack = 1'b1;
    step(3);
    p1_attack = 1'b0;
    tests_run++;
    if ({player2_health, p1_busy, p1_landed} !== {3'd5, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL disabled_ignores: got h2=%0d busy=%b landed=%b, want 5 0 0",
               player2_health, p1_busy, p1_landed);
    end
  endtask

  initial begin
    reset = 1'b1;
    game_state = 3'd0;
    clear_inputs();
    #1;
    test_reset();
    test_round_start_single_hit();
    test_held_attack();
    test_block_and_range();
    test_exit_priority();
    test_double_ko();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
